// File: rtl/reaction_multi_timer_pkg.sv
// Shared definitions for the multi-player reaction timer: FSM state codes,
// LFSR constants and width helpers.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        GO     = 2'd2,
        RESULT = 2'd3
    } state_t;

    // 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [15:0] TAP_MASK = 16'hB400;

    // Ceiling log2; clog2(0) = clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

    // Index width for n players, never narrower than one bit
    function automatic int unsigned win_width(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/reaction_multi_timer_ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every CYCLES clocks, with a
// synchronous clear that restarts the count from zero.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int unsigned CYCLES = 10_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned     CNT_W = (CYCLES <= 1) ? 1 : clog2(CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Prescaler counter: wraps after LAST, restarts on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear_i || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_o = (cnt == LAST);

endmodule

// File: rtl/reaction_multi_timer.sv
// N-player reaction timer: random pre-go delay, per-player ms timing of the
// first press, false-start detection, winner/tie selection and best-time record.
module reaction_multi_timer
    import reaction_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned CLK_HZ          = 10_000_000,
    parameter int unsigned TIME_W          = 14,
    parameter int unsigned TIMEOUT_MS      = 9999,
    parameter int unsigned DELAY_MIN_MS    = 1000,
    parameter int unsigned DELAY_SPAN_LOG2 = 11
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_i,
    input  logic [NUM_PLAYERS-1:0]                react_i,
    output logic                                  led_o,
    output logic [1:0]                            state_o,
    output logic                                  done_o,
    output logic                                  winner_valid_o,
    output logic [win_width(NUM_PLAYERS)-1:0]     winner_o,
    output logic                                  tie_o,
    output logic [NUM_PLAYERS-1:0]                false_start_o,
    output logic [NUM_PLAYERS*TIME_W-1:0]         time_o,
    output logic [TIME_W-1:0]                     best_o,
    output logic                                  best_valid_o
);

    localparam int unsigned       WIN_W     = win_width(NUM_PLAYERS);
    localparam logic [TIME_W-1:0] T_MAX     = TIME_W'(TIMEOUT_MS);
    localparam logic [TIME_W-1:0] T_LAST    = TIME_W'(TIMEOUT_MS - 1);
    localparam logic [15:0]       SPAN_MASK = 16'((64'd1 << DELAY_SPAN_LOG2) - 64'd1);

    state_t                   state, state_nxt;
    logic                     start_q;
    logic [NUM_PLAYERS-1:0]   react_q;
    logic                     start_ev;
    logic [NUM_PLAYERS-1:0]   react_ev;
    logic [15:0]              lfsr;
    logic                     tick;
    logic                     round_start;
    logic [TIME_W-1:0]        delay_load;
    logic [TIME_W-1:0]        delay_cnt;
    logic [TIME_W-1:0]        ms_cnt;
    logic [TIME_W-1:0]        win_time;
    logic [TIME_W-1:0]        best_q;
    logic [NUM_PLAYERS-1:0]   fs_q;
    logic [NUM_PLAYERS-1:0]   latched_q;
    logic [NUM_PLAYERS-1:0]   arm_flags;
    logic [NUM_PLAYERS-1:0]   latch_ev;
    logic [TIME_W-1:0]        times_q [NUM_PLAYERS];
    logic                     win_valid_q;
    logic                     tie_q;
    logic                     best_valid_q;
    logic                     done_q;
    logic [WIN_W-1:0]         win_idx_q;
    logic [WIN_W-1:0]         first_idx;
    logic                     multi_latch;
    logic                     any_latch;
    logic                     all_done;
    logic                     timeout_hit;

    ms_tick_gen #(
        .CYCLES (CLK_HZ / 1000)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (round_start),
        .tick_o  (tick)
    );

    // Button history; reset high so a button held through reset gives no edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b1;
            react_q <= '1;
        end else begin
            start_q <= start_i;
            react_q <= react_i;
        end
    end

    assign start_ev = start_i & ~start_q;
    assign react_ev = react_i & ~react_q;

    // Free-running LFSR supplying the random part of the pre-go delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & TAP_MASK)};
        end
    end

    // Round-control helpers: eligible latches, winner pick, end conditions
    always_comb begin
        round_start = start_ev && (state == IDLE || state == RESULT);
        delay_load  = TIME_W'(DELAY_MIN_MS) + TIME_W'(lfsr & SPAN_MASK);
        arm_flags   = fs_q | react_ev;
        latch_ev    = react_ev & ~fs_q & ~latched_q;
        all_done    = &(fs_q | latched_q | latch_ev);
        timeout_hit = tick && (ms_cnt == T_LAST);
        first_idx   = '0;
        multi_latch = 1'b0;
        any_latch   = 1'b0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (latch_ev[i]) begin
                if (!any_latch) first_idx = WIN_W'(i);
                else            multi_latch = 1'b1;
                any_latch = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic; an all-flagged field ends the round before GO
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESULT: if (start_ev) state_nxt = ARM;
            ARM: begin
                if (&arm_flags)                      state_nxt = RESULT;
                else if (tick && delay_cnt == '0)    state_nxt = GO;
            end
            GO:  if (all_done || timeout_hit)        state_nxt = RESULT;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        led_o   = (state == GO);
        state_o = state;
    end

    // Round datapath: delay/ms counters, flags, latched times, winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_cnt   <= '0;
            ms_cnt      <= '0;
            fs_q        <= '0;
            latched_q   <= '0;
            win_valid_q <= 1'b0;
            tie_q       <= 1'b0;
            win_idx_q   <= '0;
            win_time    <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) times_q[i] <= '0;
        end else if (round_start) begin
            delay_cnt   <= delay_load;
            ms_cnt      <= '0;
            fs_q        <= '0;
            latched_q   <= '0;
            win_valid_q <= 1'b0;
            tie_q       <= 1'b0;
            win_idx_q   <= '0;
            win_time    <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) times_q[i] <= '0;
        end else if (state == ARM) begin
            fs_q <= arm_flags;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (react_ev[i]) times_q[i] <= T_MAX;
            end
            if (tick && delay_cnt != '0) delay_cnt <= delay_cnt - TIME_W'(1);
        end else if (state == GO) begin
            if (tick && ms_cnt != T_MAX) ms_cnt <= ms_cnt + TIME_W'(1);
            latched_q <= latched_q | latch_ev;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                if (latch_ev[i])
                    times_q[i] <= ms_cnt;
                else if (timeout_hit && !fs_q[i] && !latched_q[i])
                    times_q[i] <= T_MAX;
            end
            if (!win_valid_q && any_latch) begin
                win_valid_q <= 1'b1;
                win_idx_q   <= first_idx;
                tie_q       <= multi_latch;
                win_time    <= ms_cnt;
            end
        end
    end

    // Result entry pulse and best-time record, updated during the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q       <= 1'b0;
            best_q       <= '0;
            best_valid_q <= 1'b0;
        end else begin
            done_q <= (state != RESULT) && (state_nxt == RESULT);
            if (done_q && win_valid_q && (!best_valid_q || win_time < best_q)) begin
                best_q       <= win_time;
                best_valid_q <= 1'b1;
            end
        end
    end

    // Pack per-player times onto the flat output bus
    always_comb begin
        time_o = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            time_o[i*TIME_W +: TIME_W] = times_q[i];
        end
    end

    assign done_o         = done_q;
    assign winner_valid_o = win_valid_q;
    assign winner_o       = win_idx_q;
    assign tie_o          = tie_q;
    assign false_start_o  = fs_q;
    assign best_o         = best_q;
    assign best_valid_o   = best_valid_q;

endmodule

// File: tb/tb_reaction_multi_timer.sv
// Testbench for reaction_multi_timer: directed rounds from the test plan plus
// randomized rounds, checked against a timing model built from the round rules.
module tb_reaction_multi_timer;

    localparam int NP     = 2;
    localparam int CLK_HZ = 10_000;
    localparam int C      = CLK_HZ / 1000;      // cycles per ms
    localparam int TW     = 14;
    localparam int TMO    = 300;                // shortened timeout keeps runtime small
    localparam int DMIN   = 5;
    localparam int G      = (DMIN + 1) * C;     // edge (relative to start) entering GO
    localparam int TEDGE  = G + TMO * C;        // edge where the ms count reaches TMO

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [NP-1:0]     react_i;
    logic              led_o;
    logic [1:0]        state_o;
    logic              done_o;
    logic              winner_valid_o;
    logic [0:0]        winner_o;
    logic              tie_o;
    logic [NP-1:0]     false_start_o;
    logic [NP*TW-1:0]  time_o;
    logic [TW-1:0]     best_o;
    logic              best_valid_o;

    reaction_multi_timer #(
        .NUM_PLAYERS     (NP),
        .CLK_HZ          (CLK_HZ),
        .TIME_W          (TW),
        .TIMEOUT_MS      (TMO),
        .DELAY_MIN_MS    (DMIN),
        .DELAY_SPAN_LOG2 (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .react_i        (react_i),
        .led_o          (led_o),
        .state_o        (state_o),
        .done_o         (done_o),
        .winner_valid_o (winner_valid_o),
        .winner_o       (winner_o),
        .tie_o          (tie_o),
        .false_start_o  (false_start_o),
        .time_o         (time_o),
        .best_o         (best_o),
        .best_valid_o   (best_valid_o)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Round schedule, as edge offsets from the start edge (-1 = none)
    int press_edge   [NP];
    int repress_edge [NP];
    int restart_edge;

    // Reference model results
    bit exp_fs   [NP];
    int exp_time [NP];
    bit exp_wv;
    bit exp_tie;
    int exp_win;
    int exp_end;
    bit exp_go;
    int model_best;
    bit model_bv;

    // Observations gathered while a round runs
    int obs_done_cnt;
    int obs_done_at;
    int obs_led_first;
    int obs_led_last;
    int obs_state[$];

    // Model: derive the round outcome from the press schedule
    task automatic model_round();
        bit all_fs;
        bit all_lat;
        int last;
        int first_edge;
        all_fs = 1'b1;
        for (int p = 0; p < NP; p++) begin
            exp_fs[p] = (press_edge[p] >= 1) && (press_edge[p] <= G);
            if (!exp_fs[p]) all_fs = 1'b0;
        end
        exp_wv = 1'b0; exp_tie = 1'b0; exp_win = 0; first_edge = -1;
        if (all_fs) begin
            exp_go  = 1'b0;
            exp_end = 0;
            for (int p = 0; p < NP; p++) begin
                if (press_edge[p] > exp_end) exp_end = press_edge[p];
                exp_time[p] = TMO;
            end
        end else begin
            exp_go = 1'b1; all_lat = 1'b1; last = G;
            for (int p = 0; p < NP; p++) begin
                if (!exp_fs[p]) begin
                    if (press_edge[p] > G && press_edge[p] <= TEDGE) begin
                        if (press_edge[p] > last) last = press_edge[p];
                    end else begin
                        all_lat = 1'b0;
                    end
                end
            end
            exp_end = all_lat ? last : TEDGE;
            for (int p = 0; p < NP; p++) begin
                if (exp_fs[p]) begin
                    exp_time[p] = TMO;
                end else if (press_edge[p] > G && press_edge[p] <= exp_end) begin
                    exp_time[p] = (press_edge[p] - G - 1) / C;
                    if (!exp_wv || press_edge[p] < first_edge) begin
                        exp_wv = 1'b1; exp_win = p; first_edge = press_edge[p]; exp_tie = 1'b0;
                    end else if (press_edge[p] == first_edge) begin
                        exp_tie = 1'b1;
                    end
                end else begin
                    exp_time[p] = TMO;
                end
            end
        end
        if (exp_wv && (!model_bv || exp_time[exp_win] < model_best)) begin
            model_best = exp_time[exp_win];
            model_bv   = 1'b1;
        end
    endtask

    // Drive one round from the schedule and record what the DUT shows
    task automatic run_round();
        int last_k;
        last_k = exp_end;
        for (int p = 0; p < NP; p++) begin
            if (press_edge[p] >= 0 && press_edge[p] + 3 > last_k) last_k = press_edge[p] + 3;
            if (repress_edge[p] >= 0 && repress_edge[p] + 1 > last_k) last_k = repress_edge[p] + 1;
        end
        if (restart_edge >= 0 && restart_edge + 2 > last_k) last_k = restart_edge + 2;
        last_k += 4;
        obs_done_cnt = 0; obs_done_at = -1; obs_led_first = -1; obs_led_last = -1;
        obs_state.delete();
        for (int k = 0; k <= last_k; k++) begin
            start_i = (k <= 1) || (restart_edge >= 0 && (k == restart_edge || k == restart_edge + 1));
            for (int p = 0; p < NP; p++) begin
                react_i[p] = (press_edge[p] >= 0 && k >= press_edge[p] && k < press_edge[p] + 3) ||
                             (repress_edge[p] >= 0 && k == repress_edge[p]);
            end
            @(posedge clk);
            @(negedge clk);
            obs_state.push_back(int'(state_o));
            if (led_o) begin
                if (obs_led_first < 0) obs_led_first = k;
                obs_led_last = k;
            end
            if (done_o) begin
                obs_done_cnt++;
                obs_done_at = k;
            end
        end
        start_i = 1'b0;
        react_i = '0;
    endtask

    task automatic clear_schedule();
        for (int p = 0; p < NP; p++) begin
            press_edge[p]   = -1;
            repress_edge[p] = -1;
        end
        restart_edge = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; react_i = '1;
        repeat (3) @(negedge clk);
        vectors++; if (state_o !== 2'd0 || led_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL reset_in: state=%0d led=%0b done=%0b want 0", state_o, led_o, done_o); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (state_o !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_o); end
        vectors++; if (winner_valid_o !== 1'b0 || winner_o !== 1'b0 || tie_o !== 1'b0) begin miscompares++; $display("FAIL reset_winner: wv=%0b w=%0d tie=%0b want 0", winner_valid_o, winner_o, tie_o); end
        vectors++; if (time_o !== '0 || best_o !== '0 || best_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_times: time=%h best=%0d bv=%0b want 0", time_o, best_o, best_valid_o); end
        react_i = '0;
        repeat (3) @(negedge clk);
        vectors++; if (false_start_o !== 2'b00 || state_o !== 2'd0) begin miscompares++; $display("FAIL reset_release: fs=%b state=%0d want 00/0", false_start_o, state_o); end
    endtask

    task automatic test_basic();
        clear_schedule();
        press_edge[0] = G + 1 + 37 * C + int'($urandom_range(0, C - 1));
        press_edge[1] = G + 1 + 52 * C + int'($urandom_range(0, C - 1));
        model_round();
        run_round();
        vectors++; if (time_o[TW-1:0] !== 14'd37) begin miscompares++; $display("FAIL basic_time0: got %0d want 37", time_o[TW-1:0]); end
        vectors++; if (time_o[2*TW-1:TW] !== 14'd52) begin miscompares++; $display("FAIL basic_time1: got %0d want 52", time_o[2*TW-1:TW]); end
        vectors++; if (winner_valid_o !== 1'b1 || winner_o !== 1'b0 || tie_o !== 1'b0) begin miscompares++; $display("FAIL basic_winner: wv=%0b w=%0d tie=%0b want 1/0/0", winner_valid_o, winner_o, tie_o); end
        vectors++; if (obs_done_cnt !== 1 || obs_done_at !== exp_end) begin miscompares++; $display("FAIL basic_done: count=%0d at=%0d want 1 at %0d", obs_done_cnt, obs_done_at, exp_end); end
        vectors++; if (obs_led_first !== G) begin miscompares++; $display("FAIL basic_led_rise: got %0d want %0d", obs_led_first, G); end
        vectors++; if (best_o !== 14'd37 || best_valid_o !== 1'b1) begin miscompares++; $display("FAIL basic_best: got %0d/%0b want 37/1", best_o, best_valid_o); end
    endtask

    task automatic test_false_start();
        clear_schedule();
        press_edge[1] = int'($urandom_range(1, G));
        press_edge[0] = G + 1 + 20 * C + int'($urandom_range(0, C - 1));
        model_round();
        run_round();
        vectors++; if (false_start_o !== 2'b10) begin miscompares++; $display("FAIL fs_flags: got %b want 10", false_start_o); end
        vectors++; if (time_o[2*TW-1:TW] !== 14'(TMO)) begin miscompares++; $display("FAIL fs_time1: got %0d want %0d", time_o[2*TW-1:TW], TMO); end
        vectors++; if (time_o[TW-1:0] !== 14'd20) begin miscompares++; $display("FAIL fs_time0: got %0d want 20", time_o[TW-1:0]); end
        vectors++; if (winner_valid_o !== 1'b1 || winner_o !== 1'b0) begin miscompares++; $display("FAIL fs_winner: wv=%0b w=%0d want 1/0", winner_valid_o, winner_o); end
        vectors++; if (best_o !== 14'd20) begin miscompares++; $display("FAIL fs_best: got %0d want 20", best_o); end
    endtask

    task automatic test_tie();
        clear_schedule();
        press_edge[0] = G + 1 + 15 * C + int'($urandom_range(0, C - 1));
        press_edge[1] = press_edge[0];
        model_round();
        run_round();
        vectors++; if (winner_valid_o !== 1'b1 || winner_o !== 1'b0 || tie_o !== 1'b1) begin miscompares++; $display("FAIL tie_winner: wv=%0b w=%0d tie=%0b want 1/0/1", winner_valid_o, winner_o, tie_o); end
        vectors++; if (time_o !== {14'd15, 14'd15}) begin miscompares++; $display("FAIL tie_times: got %0d,%0d want 15,15", time_o[2*TW-1:TW], time_o[TW-1:0]); end
        vectors++; if (best_o !== 14'd15) begin miscompares++; $display("FAIL tie_best: got %0d want 15", best_o); end
        vectors++; if (obs_done_at !== exp_end) begin miscompares++; $display("FAIL tie_done_at: got %0d want %0d", obs_done_at, exp_end); end
    endtask

    task automatic test_all_false();
        clear_schedule();
        press_edge[0] = int'($urandom_range(1, G));
        press_edge[1] = int'($urandom_range(1, G));
        model_round();
        run_round();
        vectors++; if (obs_led_first !== -1) begin miscompares++; $display("FAIL allfs_led: led rose at %0d want never", obs_led_first); end
        vectors++; if (state_o !== 2'd3 || obs_done_at !== exp_end) begin miscompares++; $display("FAIL allfs_result: state=%0d done_at=%0d want 3 at %0d", state_o, obs_done_at, exp_end); end
        vectors++; if (false_start_o !== 2'b11 || winner_valid_o !== 1'b0) begin miscompares++; $display("FAIL allfs_flags: fs=%b wv=%0b want 11/0", false_start_o, winner_valid_o); end
        vectors++; if (best_o !== 14'd15 || best_valid_o !== 1'b1) begin miscompares++; $display("FAIL allfs_best: got %0d/%0b want 15/1", best_o, best_valid_o); end
    endtask

    task automatic test_timeout();
        clear_schedule();
        restart_edge = G + 50 * C;   // start pressed during GO must be ignored
        model_round();
        run_round();
        vectors++; if (obs_done_at !== TEDGE || obs_done_cnt !== 1) begin miscompares++; $display("FAIL tmo_done: at=%0d count=%0d want %0d/1", obs_done_at, obs_done_cnt, TEDGE); end
        vectors++; if (time_o !== {14'(TMO), 14'(TMO)}) begin miscompares++; $display("FAIL tmo_times: got %0d,%0d want %0d", time_o[2*TW-1:TW], time_o[TW-1:0], TMO); end
        vectors++; if (winner_valid_o !== 1'b0 || state_o !== 2'd3) begin miscompares++; $display("FAIL tmo_winner: wv=%0b state=%0d want 0/3", winner_valid_o, state_o); end
        vectors++; if (obs_led_first !== G || obs_led_last !== TEDGE - 1) begin miscompares++; $display("FAIL tmo_led: %0d..%0d want %0d..%0d", obs_led_first, obs_led_last, G, TEDGE - 1); end
        vectors++; if (best_o !== 14'd15) begin miscompares++; $display("FAIL tmo_best: got %0d want 15", best_o); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            clear_schedule();
            for (int p = 0; p < NP; p++) begin
                int mode;
                mode = int'($urandom_range(0, 9));
                if (mode <= 1)      press_edge[p] = int'($urandom_range(1, G));
                else if (mode == 2) press_edge[p] = -1;
                else                press_edge[p] = G + 1 + int'($urandom_range(0, 40)) * C + int'($urandom_range(0, C - 1));
                if (press_edge[p] >= 0 && $urandom_range(0, 1) == 1)
                    repress_edge[p] = press_edge[p] + 5 + int'($urandom_range(0, 20));
            end
            if (press_edge[0] > G && press_edge[1] > G && $urandom_range(0, 3) == 0)
                press_edge[1] = press_edge[0];
            model_round();
            if (exp_end >= 3 && $urandom_range(0, 1) == 1)
                restart_edge = int'($urandom_range(3, exp_end));
            run_round();
            for (int k = 0; k < obs_state.size(); k++) begin
                int want;
                want = (k >= exp_end) ? 3 : ((exp_go && k >= G) ? 2 : 1);
                vectors++; if (obs_state[k] !== want) begin miscompares++; $display("FAIL rnd%0d_state k=%0d: got %0d want %0d", r, k, obs_state[k], want); end
            end
            vectors++; if (obs_led_first !== (exp_go ? G : -1) || obs_led_last !== (exp_go ? exp_end - 1 : -1)) begin miscompares++; $display("FAIL rnd%0d_led: %0d..%0d want go=%0b end=%0d", r, obs_led_first, obs_led_last, exp_go, exp_end); end
            vectors++; if (obs_done_cnt !== 1 || obs_done_at !== exp_end) begin miscompares++; $display("FAIL rnd%0d_done: count=%0d at=%0d want 1 at %0d", r, obs_done_cnt, obs_done_at, exp_end); end
            for (int p = 0; p < NP; p++) begin
                vectors++; if (time_o[p*TW +: TW] !== TW'(exp_time[p]) || false_start_o[p] !== exp_fs[p]) begin miscompares++; $display("FAIL rnd%0d_p%0d: time=%0d fs=%0b want %0d/%0b", r, p, time_o[p*TW +: TW], false_start_o[p], exp_time[p], exp_fs[p]); end
            end
            vectors++; if (winner_valid_o !== exp_wv || (exp_wv && (winner_o !== 1'(exp_win) || tie_o !== exp_tie))) begin miscompares++; $display("FAIL rnd%0d_winner: wv=%0b w=%0d tie=%0b want %0b/%0d/%0b", r, winner_valid_o, winner_o, tie_o, exp_wv, exp_win, exp_tie); end
            vectors++; if (best_o !== TW'(model_best) || best_valid_o !== model_bv) begin miscompares++; $display("FAIL rnd%0d_best: got %0d/%0b want %0d/%0b", r, best_o, best_valid_o, model_best, model_bv); end
        end
    endtask

    task automatic test_reset_mid_go();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (G + 20) @(negedge clk);
        vectors++; if (led_o !== 1'b1 || state_o !== 2'd2) begin miscompares++; $display("FAIL midgo_pre: led=%0b state=%0d want 1/2", led_o, state_o); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (state_o !== 2'd0 || led_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL midgo_ctrl: state=%0d led=%0b done=%0b want 0", state_o, led_o, done_o); end
        vectors++; if (best_o !== '0 || best_valid_o !== 1'b0 || time_o !== '0 || false_start_o !== '0 || winner_valid_o !== 1'b0) begin miscompares++; $display("FAIL midgo_data: best=%0d bv=%0b time=%h fs=%b wv=%0b want 0", best_o, best_valid_o, time_o, false_start_o, winner_valid_o); end
        model_best = 0;
        model_bv   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (state_o !== 2'd0 || best_valid_o !== 1'b0) begin miscompares++; $display("FAIL midgo_after: state=%0d bv=%0b want 0/0", state_o, best_valid_o); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_best  = 0;
        model_bv    = 1'b0;
        clear_schedule();
        test_reset();
        test_basic();
        test_false_start();
        test_tie();
        test_all_false();
        test_timeout();
        test_random();
        test_reset_mid_go();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1);
    end

endmodule

// File: doc/reaction_multi_timer.md
Name: reaction_multi_timer

Overview:
N-player reaction-time core, the parametrised successor of the single-player reaction FSM and timer pair.
- On start, waits a pseudo-random delay, then lights the go LED and times every player's first press in milliseconds.
- Flags false starts, picks a winner and keeps a best-time record across rounds.
- Feeds the existing 7-segment driver and top-level pin mapping.

Parameters:
- NUM_PLAYERS, 2, number of react inputs (1..8).
- CLK_HZ, 10_000_000, clock frequency; ms tick every CLK_HZ/1000 cycles.
- TIME_W, 14, width of all ms values.
- TIMEOUT_MS, 9999, saturation and timeout value, so it always fits a 4-digit display.
- DELAY_MIN_MS, 1000, fixed part of the pre-go delay.
- DELAY_SPAN_LOG2, 11, random part width: 0..2^DELAY_SPAN_LOG2-1 ms. A value of 0 gives a fixed delay.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  start button, synchronous and debounced upstream
- react_i  in  NUM_PLAYERS  react buttons, synchronous and debounced upstream
- led_o  out  1  go stimulus; high only in GO
- state_o  out  2  current FSM state code
- done_o  out  1  one-cycle pulse on entry to RESULT
- winner_valid_o  out  1  a winner exists for the last round
- winner_o  out  WIN_W  winner index; WIN_W = max(1, clog2(NUM_PLAYERS))
- tie_o  out  1  more than one player latched the winning time in the same cycle
- false_start_o  out  NUM_PLAYERS  per-player disqualification flags
- time_o  out  NUM_PLAYERS*TIME_W  per-player latched times; player p occupies [p*TIME_W +: TIME_W]
- best_o  out  TIME_W  best winning time since reset
- best_valid_o  out  1  best_o holds a valid time

Behaviour:
- Reset (async assert, sync release):
  - FSM in IDLE; all outputs 0, including best_valid_o.
  - Edge-detect history registers reset to all-ones, so a button held through reset creates no edge.
  - LFSR is loaded with SEED.
- Edge detection: event = input high AND history low, one register stage. The action taken on an event happens on that same clock edge.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, free-running every cycle.
- FSM states: IDLE=0, ARM=1, GO=2, RESULT=3.
- IDLE or RESULT, on start event:
  - Load delay = DELAY_MIN_MS + lfsr[DELAY_SPAN_LOG2-1:0].
  - Clear times, flags, winner_valid_o and tie_o; clear the prescaler.
  - Go to ARM.
- ARM:
  - The delay counter decrements on each ms tick; when it is 0 at a tick, go to GO.
  - A react event from player p sets false_start_o[p]. Player p is ignored for the rest of the round and time_o[p] = TIMEOUT_MS.
  - If all players are flagged, go directly to RESULT with winner_valid_o = 0.
- GO:
  - led_o = 1. The ms counter starts at 0, increments on each tick and saturates at TIMEOUT_MS.
  - The first react event from each eligible player latches the current count into time_o[p]. Later presses from that player are ignored.
  - Winner is the first latch in the round. Simultaneous first latches: lowest index wins and tie_o = 1.
  - Go to RESULT when every eligible player has latched, or at the tick where the count reaches TIMEOUT_MS. Unlatched players then get TIMEOUT_MS and cannot win.
  - If nobody latched, winner_valid_o = 0.
- RESULT:
  - Entry produces done_o for one cycle.
  - If winner_valid_o and (!best_valid_o or winner time < best_o): best_o is updated and best_valid_o is set, registered on the done cycle.
  - Results hold until the next start event.
- Start events in ARM or GO are ignored (no restart mid-round). A react event in IDLE or RESULT is ignored.
- Reset mid-round aborts immediately to the reset state; best_o is lost.

Decomposition:
- Package reaction_pkg holds: state encoding constants, LFSR SEED = 16'hACE1 and tap mask, and a clog2 helper.
- One sub-module: ms_tick_gen.
  - Prescaler with synchronous clear.
  - Parameter CYCLES = CLK_HZ/1000.
  - Output tick_o: one-cycle pulse on each prescaler wrap.

Test Plan (CLK_HZ=10_000, i.e. 10 cycles/ms; DELAY_SPAN_LOG2=0; DELAY_MIN_MS=5; NUM_PLAYERS=2):
1. Reset with react_i=2'b11 held, then release buttons -> no false start, state_o=0, all outputs 0.
2. Start; P0 presses 37 ms after led_o rises; P1 presses at 52 ms -> time_o = {52,37}, winner_o=0, winner_valid_o=1, done_o pulses once, best_o=37, best_valid_o=1.
3. Start; P1 presses during ARM; P0 presses at 20 ms -> false_start_o=2'b10, time_o[1]=9999, winner_o=0, best_o=20.
4. Start; both press in the same cycle at 15 ms -> winner_o=0, tie_o=1, both times 15, best_o=15.
5. Start; both press during ARM -> direct ARM->RESULT, led_o never asserts, winner_valid_o=0, best_o unchanged.
6. Start; no presses -> RESULT at count 9999, both times 9999, winner_valid_o=0. Also: start pressed during GO is ignored; rst_n pulsed mid-GO clears all outputs within the same cycle.
